pixel_sink_fb_writer: RTL and testbench

//  Consumer end of the pixel stream produced by the shape/rectangle generators.

---
 rtl/pixel_sink_fb_writer.sv | 153 +++++++++++++++
 tb/tb_pixel_sink_fb_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sink_fb_writer.sv
// Pixel stream sink: FIFO-buffered, clipped, addressed framebuffer writes plus a full-screen fill engine.
// Optional PIXEL_SINK_STATS_EN adds a saturating clip_count output.
module pixel_sink_fb_writer #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_x,
    input  logic [7:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              clear_req,
    input  logic [2:0]        clear_colour,
    output logic              clear_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_busy,
`ifdef PIXEL_SINK_STATS_EN
    output logic [15:0]       clip_count,
`endif
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    DEPTH     = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]       W_LIM     = SCREEN_W;
    localparam logic [31:0]       H_LIM     = SCREEN_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W*SCREEN_H-1);

    typedef enum logic [1:0] {RUN, DRAIN, FILL} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        data_q, data_d, fill_colour_q, fill_colour_d;
    logic              we_q, we_d, done_q, done_d;

    logic [8:0] x_mem [FIFO_DEPTH];
    logic [7:0] y_mem [FIFO_DEPTH];
    logic [2:0] c_mem [FIFO_DEPTH];

    logic fifo_empty, fifo_full, accept, on_screen, push, pop;
    logic [ADDR_W-1:0] pop_addr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH);
    assign in_ready   = (state_q == RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign on_screen  = (32'(in_x) < W_LIM) && (32'(in_y) < H_LIM);
    assign push       = accept && on_screen;
    // Stage2 frees up either when empty or when its write retires this cycle.
    assign pop        = !fifo_empty && (!we_q || !fb_busy);
    assign pop_addr   = ADDR_W'(y_mem[rd_ptr_q]) * ADDR_W'(SCREEN_W) + ADDR_W'(x_mem[rd_ptr_q]);

    always_ff @(posedge clock) begin
        if (push) begin
            x_mem[wr_ptr_q] <= in_x;
            y_mem[wr_ptr_q] <= in_y;
            c_mem[wr_ptr_q] <= in_colour;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        we_d          = we_q;
        fill_colour_d = fill_colour_q;
        done_d        = 1'b0;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        if (we_q && !fb_busy) we_d = 1'b0;
        if (pop) begin
            addr_d = pop_addr;
            data_d = c_mem[rd_ptr_q];
            we_d   = 1'b1;
        end
        case (state_q)
            RUN: if (clear_req) begin
                fill_colour_d = clear_colour;
                state_d       = DRAIN;
            end
            DRAIN: if (fifo_empty && (!we_q || !fb_busy)) begin
                state_d = FILL;
                addr_d  = '0;
                data_d  = fill_colour_q;
                we_d    = 1'b1;
            end
            FILL: if (!fb_busy) begin
                if (addr_q == LAST_ADDR) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            we_q          <= 1'b0;
            fill_colour_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            we_q          <= we_d;
            fill_colour_q <= fill_colour_d;
            done_q        <= done_d;
        end
    end

`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] clip_count_q, clip_count_d;
    always_comb begin
        clip_count_d = clip_count_q;
        if (accept && !on_screen && clip_count_q != 16'hFFFF) clip_count_d = clip_count_q + 16'd1;
    end
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) clip_count_q <= '0;
        else      clip_count_q <= clip_count_d;
    end
    assign clip_count = clip_count_q;
`endif

    assign fb_addr    = addr_q;
    assign fb_data    = data_q;
    assign fb_we      = we_q;
    assign clear_done = done_q;
    assign busy       = !fifo_empty || we_q || (state_q != RUN);
endmodule

// File: tb/tb_pixel_sink_fb_writer.sv
// Directed bench: a full-size instance (320x240) for streaming/clipping and an 8x4 instance for fill tests.
module tb_pixel_sink_fb_writer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    logic        a_rst, a_in_valid, a_in_ready, a_clear_req, a_clear_done, a_fb_we, a_fb_busy, a_busy;
    logic [8:0]  a_in_x;
    logic [7:0]  a_in_y;
    logic [2:0]  a_in_colour, a_clear_colour, a_fb_data;
    logic [16:0] a_fb_addr;
    logic        b_rst, b_in_valid, b_in_ready, b_clear_req, b_clear_done, b_fb_we, b_fb_busy, b_busy;
    logic [8:0]  b_in_x;
    logic [7:0]  b_in_y;
    logic [2:0]  b_in_colour, b_clear_colour, b_fb_data;
    logic [4:0]  b_fb_addr;
`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] a_clip_count, b_clip_count;
`endif

    pixel_sink_fb_writer #(.SCREEN_W(320), .SCREEN_H(240), .FIFO_DEPTH(4), .ADDR_W(17)) dut_a (
        .clock(clock), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y), .in_colour(a_in_colour), .clear_req(a_clear_req),
        .clear_colour(a_clear_colour), .clear_done(a_clear_done), .fb_addr(a_fb_addr),
        .fb_data(a_fb_data), .fb_we(a_fb_we), .fb_busy(a_fb_busy),
`ifdef PIXEL_SINK_STATS_EN
        .clip_count(a_clip_count),
`endif
        .busy(a_busy));

    pixel_sink_fb_writer #(.SCREEN_W(8), .SCREEN_H(4), .FIFO_DEPTH(4), .ADDR_W(5)) dut_b (
        .clock(clock), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y), .in_colour(b_in_colour), .clear_req(b_clear_req),
        .clear_colour(b_clear_colour), .clear_done(b_clear_done), .fb_addr(b_fb_addr),
        .fb_data(b_fb_data), .fb_we(b_fb_we), .fb_busy(b_fb_busy),
`ifdef PIXEL_SINK_STATS_EN
        .clip_count(b_clip_count),
`endif
        .busy(b_busy));

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        {a_in_valid, a_clear_req, a_fb_busy, b_in_valid, b_clear_req, b_fb_busy} = '0;
        {a_in_x, a_in_y, a_in_colour, a_clear_colour} = '0;
        {b_in_x, b_in_y, b_in_colour, b_clear_colour} = '0;
        a_rst = 1'b1; b_rst = 1'b1;
        #2; a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) @(posedge clock); #1;
        n_cmp++; if (a_fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", a_fb_we); end
        n_cmp++; if (a_fb_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", a_fb_addr); end
        n_cmp++; if (a_fb_data !== 3'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", a_fb_data); end
        n_cmp++; if (a_clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", a_clear_done); end
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_cmp++; if (b_fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_b: got %b want 0", b_fb_we); end
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_in_ready); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %b want 1", b_in_ready); end
        step();
    endtask

    task automatic test_single();
        a_in_valid = 1'b1; a_in_x = 9'd5; a_in_y = 8'd2; a_in_colour = 3'b101;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_in_ready); end
        step(); a_in_valid = 1'b0;
        n_cmp++; if (a_fb_we !== 1'b0) begin n_fail++; $display("FAIL single_lat1_we: got %b want 0", a_fb_we); end
        step();
        n_cmp++; if (a_fb_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", a_fb_we); end
        n_cmp++; if (a_fb_addr !== 17'd645) begin n_fail++; $display("FAIL single_addr: got %0d want 645", a_fb_addr); end
        n_cmp++; if (a_fb_data !== 3'b101) begin n_fail++; $display("FAIL single_data: got %0d want 5", a_fb_data); end
        step();
        n_cmp++; if (a_fb_we !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got we=%b busy=%b want 0 0", a_fb_we, a_busy); end
    endtask

    task automatic test_clip();
        int seen;
        seen = 0;
        a_in_valid = 1'b1; a_in_x = 9'd319; a_in_y = 8'd239; a_in_colour = 3'd3;
        step(); a_in_valid = 1'b0;
        step();
        n_cmp++; if (a_fb_we !== 1'b1 || a_fb_addr !== 17'd76799) begin n_fail++; $display("FAIL clip_corner_addr: got we=%b addr=%0d want 1 76799", a_fb_we, a_fb_addr); end
        a_in_valid = 1'b1; a_in_x = 9'd320; a_in_y = 8'd0;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL clip_x_ready: got %b want 1", a_in_ready); end
        step();
        a_in_x = 9'd0; a_in_y = 8'd240;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL clip_y_ready: got %b want 1", a_in_ready); end
        step(); a_in_valid = 1'b0;
        repeat (4) begin if (a_fb_we !== 1'b0 || a_busy !== 1'b0) seen++; step(); end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL clip_no_write: got %0d active cycles want 0", seen); end
`ifdef PIXEL_SINK_STATS_EN
        n_cmp++; if (a_clip_count !== 16'd2) begin n_fail++; $display("FAIL clip_count: got %0d want 2", a_clip_count); end
`endif
    endtask

    task automatic test_back_to_back();
        int k, w, first, bad_order, bad_gap;
        k = 0; w = 0; first = -1; bad_order = 0; bad_gap = 0;
        a_fb_busy = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            a_in_valid = (k < 8); a_in_x = 9'(10 + k); a_in_y = 8'd1; a_in_colour = 3'(k);
            if (a_in_valid && a_in_ready) k++;
            step();
        end
        n_cmp++; if (k != 5) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 5", k); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b want 0", a_in_ready); end
        a_fb_busy = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a_in_valid = (k < 8); a_in_x = 9'(10 + k); a_in_y = 8'd1; a_in_colour = 3'(k);
            if (a_in_valid && a_in_ready) k++;
            if (a_fb_we && !a_fb_busy) begin
                if (a_fb_addr !== 17'(330 + w) || a_fb_data !== 3'(w)) bad_order++;
                if (w == 0) first = cyc; else if (cyc != first + w) bad_gap++;
                w++;
            end
            step();
        end
        a_in_valid = 1'b0;
        n_cmp++; if (w != 8) begin n_fail++; $display("FAIL b2b_writes: got %0d want 8", w); end
        n_cmp++; if (bad_order != 0) begin n_fail++; $display("FAIL b2b_order: got %0d bad want 0", bad_order); end
        n_cmp++; if (bad_gap != 0) begin n_fail++; $display("FAIL b2b_rate: got %0d gaps want 0", bad_gap); end
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", a_busy); end
    endtask

    task automatic test_fill();
        int w, bad, bad_rdy, dn, post;
        w = 0; bad = 0; bad_rdy = 0; dn = 0; post = 0;
        b_clear_colour = 3'b010; b_clear_req = 1'b1;
        step(); b_clear_req = 1'b0;
        for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
            b_fb_busy = (cyc % 3 == 1);
            b_clear_req = (cyc == 5);
            b_clear_colour = (cyc == 5) ? 3'b110 : 3'b010;
            if (b_clear_done) dn++;
            if (dn == 0 && b_in_ready) bad_rdy++;
            if (b_fb_we && !b_fb_busy) begin
                if (b_fb_addr !== 5'(w) || b_fb_data !== 3'b010) bad++;
                w++;
            end
            if (dn > 0) post++;
            step();
        end
        b_fb_busy = 1'b0; b_clear_req = 1'b0;
        n_cmp++; if (w != 32) begin n_fail++; $display("FAIL fill_writes: got %0d want 32", w); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL fill_addr_data: got %0d bad want 0", bad); end
        n_cmp++; if (bad_rdy != 0) begin n_fail++; $display("FAIL fill_ready: got %0d ready cycles want 0", bad_rdy); end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL fill_done: got %0d pulses want 1", dn); end
        n_cmp++; if (b_in_ready !== 1'b1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL fill_after: got ready=%b busy=%b want 1 0", b_in_ready, b_busy); end
    endtask

    task automatic test_drain();
        int w, bad, dn, post;
        w = 0; bad = 0; dn = 0; post = 0;
        b_fb_busy = 1'b1;
        b_in_valid = 1'b1; b_in_y = 8'd1; b_in_colour = 3'b111;
        b_in_x = 9'd1; step();
        b_in_x = 9'd2; step();
        b_in_x = 9'd3; b_clear_req = 1'b1; b_clear_colour = 3'b010;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_same_cycle_ready: got %b want 1", b_in_ready); end
        step(); b_in_valid = 1'b0; b_clear_req = 1'b0;
        n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b want 0", b_in_ready); end
        b_fb_busy = 1'b0;
        for (int cyc = 0; cyc < 100 && post < 2; cyc++) begin
            if (b_clear_done) dn++;
            if (b_fb_we) begin
                if (w < 3) begin
                    if (b_fb_addr !== 5'(9 + w) || b_fb_data !== 3'b111) bad++;
                end else if (b_fb_addr !== 5'(w - 3) || b_fb_data !== 3'b010) bad++;
                w++;
            end
            if (dn > 0) post++;
            step();
        end
        n_cmp++; if (w != 35) begin n_fail++; $display("FAIL drain_writes: got %0d want 35", w); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drain_order: got %0d bad want 0", bad); end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL drain_done: got %0d pulses want 1", dn); end
    endtask

    task automatic test_reset_mid_fill();
        int t, dn;
        t = 0; dn = 0;
        b_clear_colour = 3'b100; b_clear_req = 1'b1;
        step(); b_clear_req = 1'b0;
        while (!(b_fb_we && b_fb_addr == 5'd10) && t < 50) begin step(); t++; end
        n_cmp++; if (t >= 50) begin n_fail++; $display("FAIL midfill_reach: got timeout want addr 10"); end
        b_rst = 1'b0; #1;
        n_cmp++; if (b_fb_we !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL midfill_async: got we=%b busy=%b want 0 0", b_fb_we, b_busy); end
        @(posedge clock); #1;
        b_rst = 1'b1; #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL midfill_ready: got %b want 1", b_in_ready); end
        b_in_valid = 1'b1; b_in_x = 9'd2; b_in_y = 8'd3; b_in_colour = 3'b101;
        if (b_clear_done) dn++;
        step(); b_in_valid = 1'b0;
        if (b_clear_done) dn++;
        step();
        if (b_clear_done) dn++;
        n_cmp++; if (b_fb_we !== 1'b1 || b_fb_addr !== 5'd26 || b_fb_data !== 3'b101) begin n_fail++; $display("FAIL midfill_pixel: got we=%b addr=%0d data=%0d want 1 26 5", b_fb_we, b_fb_addr, b_fb_data); end
        step();
        if (b_clear_done) dn++;
        n_cmp++; if (dn != 0) begin n_fail++; $display("FAIL midfill_no_done: got %0d pulses want 0", dn); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip();
        test_back_to_back();
        test_fill();
        test_drain();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
